// File: rtl/ws_pkg.sv
// ws_pkg -- shared definitions for the WS2812-style pixel stream controller.
//   * ws_state_e     : controller sequencing states
//   * DEF_*          : default bit/latch timing in clk cycles at 50 MHz
//   * PIXEL_BITS     : bits per colour word
//   * timing_ok()    : legality check for a set of timing parameters
package ws_pkg;

    localparam int DEF_T_BIT        = 61;     // 1220 ns bit period
    localparam int DEF_T0H          = 18;     // 360 ns high for a 0 bit
    localparam int DEF_T1H          = 33;     // 660 ns high for a 1 bit
    localparam int DEF_RESET_CYCLES = 15000;  // 300 us latch low time
    localparam int PIXEL_BITS       = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } ws_state_e;

    function automatic logic timing_ok(input int t_bit, input int t0h,
                                       input int t1h, input int reset_cycles);
        return (t0h > 0) && (t0h < t1h) && (t1h < t_bit) && (reset_cycles >= 1);
    endfunction

endpackage

// File: rtl/ws_bit_timer.sv
// ws_bit_timer -- bit-period counter and registered DO waveform generator.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   advance      : controller is in SEND this cycle (counter runs)
//   send_nxt     : controller will be in SEND next cycle
//   bit_nxt      : value of the bit that will be on the line next cycle
//   bit_end      : counter is on the final cycle of the bit period
//   do_out       : registered serial data line
module ws_bit_timer
    import ws_pkg::*;
#(
    parameter int T_BIT = DEF_T_BIT,
    parameter int T0H   = DEF_T0H,
    parameter int T1H   = DEF_T1H
) (
    input  logic clk,
    input  logic reset_n,
    input  logic advance,
    input  logic send_nxt,
    input  logic bit_nxt,
    output logic bit_end,
    output logic do_out
);

    localparam int CW = $clog2(T_BIT);
    localparam logic [CW-1:0] CYC_LAST = CW'(T_BIT - 1);
    localparam logic [CW-1:0] HI_ONE   = CW'(T1H);
    localparam logic [CW-1:0] HI_ZERO  = CW'(T0H);

    logic [CW-1:0] cyc_cnt;
    logic [CW-1:0] cyc_nxt;
    logic [CW-1:0] hi_nxt;

    assign bit_end = (cyc_cnt == CYC_LAST);

    // The counter rests at 0 outside SEND, so a freshly loaded pixel
    // starts its first bit period at cycle 0 with no extra state.
    always_comb begin
        cyc_nxt = '0;
        if (advance && !bit_end) begin
            cyc_nxt = cyc_cnt + CW'(1);
        end
        hi_nxt = bit_nxt ? HI_ONE : HI_ZERO;
    end

    // DO is registered from the next-cycle counter and bit, so the line
    // level lines up with cyc_cnt/bit_idx of the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cyc_cnt <= '0;
            do_out  <= 1'b0;
        end else begin
            cyc_cnt <= cyc_nxt;
            do_out  <= send_nxt && (cyc_nxt < hi_nxt);
        end
    end

endmodule

// File: rtl/pixel_stream_controller.sv
// pixel_stream_controller -- serialises 24-bit pixels onto a single-wire
// LED data line (MSB first), then holds the line low to latch the frame.
// Ports:
//   clk, reset_n             : 50 MHz clock, synchronous active-low reset
//   pixel_data/last/valid    : pixel stream input (valid/ready handshake)
//   pixel_ready              : pixel accepted this cycle when valid is high
//   DO                       : registered serial LED data line
//   busy                     : controller is sending or latching
//   frame_done               : one-cycle pulse as the latch period completes
//   underrun                 : one-cycle pulse when a pixel ends with no
//                              successor and was not marked last
module pixel_stream_controller
    import ws_pkg::*;
#(
    parameter int T_BIT        = DEF_T_BIT,
    parameter int T0H          = DEF_T0H,
    parameter int T1H          = DEF_T1H,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] pixel_data,
    input  logic        pixel_last,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic        DO,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    localparam int LW = $clog2(RESET_CYCLES + 1);
    localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYCLES - 1);
    localparam logic [4:0]    MSB_IDX    = 5'(PIXEL_BITS - 1);

    if (!timing_ok(T_BIT, T0H, T1H, RESET_CYCLES)) begin : g_bad_timing
        $error("pixel_stream_controller: need 0 < T0H < T1H < T_BIT and RESET_CYCLES >= 1");
    end

    ws_state_e     state, state_nxt;
    logic [23:0]   shift_q, shift_nxt;
    logic          last_q, last_nxt;
    logic [4:0]    bit_idx, bit_idx_nxt;
    logic [LW-1:0] latch_cnt, latch_nxt;
    logic          bit_end;
    logic          in_send;
    logic          send_nxt;
    logic          bit_nxt;

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        last_nxt    = last_q;
        bit_idx_nxt = bit_idx;
        latch_nxt   = latch_cnt;
        pixel_ready = 1'b0;
        frame_done  = 1'b0;
        underrun    = 1'b0;

        case (state)
            ST_IDLE: begin
                pixel_ready = 1'b1;
                if (pixel_valid) begin
                    shift_nxt   = pixel_data;
                    last_nxt    = pixel_last;
                    bit_idx_nxt = MSB_IDX;
                    state_nxt   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bit_end) begin
                    if (bit_idx == 5'd0) begin
                        // Final cycle of the pixel: chain straight into the
                        // next one, otherwise go latch the frame.
                        pixel_ready = 1'b1;
                        if (pixel_valid) begin
                            shift_nxt   = pixel_data;
                            last_nxt    = pixel_last;
                            bit_idx_nxt = MSB_IDX;
                        end else begin
                            state_nxt = ST_LATCH;
                            latch_nxt = '0;
                            underrun  = !last_q;
                        end
                    end else begin
                        bit_idx_nxt = bit_idx - 5'd1;
                    end
                end
            end
            ST_LATCH: begin
                if (latch_cnt == LATCH_LAST) begin
                    state_nxt  = ST_IDLE;
                    latch_nxt  = '0;
                    frame_done = 1'b1;
                end else begin
                    latch_nxt = latch_cnt + LW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Reset wins over everything this cycle: no acceptance, no pulses.
        if (!reset_n) begin
            pixel_ready = 1'b0;
            frame_done  = 1'b0;
            underrun    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            shift_q   <= '0;
            last_q    <= 1'b0;
            bit_idx   <= '0;
            latch_cnt <= '0;
        end else begin
            state     <= state_nxt;
            shift_q   <= shift_nxt;
            last_q    <= last_nxt;
            bit_idx   <= bit_idx_nxt;
            latch_cnt <= latch_nxt;
        end
    end

    assign busy     = (state != ST_IDLE);
    assign in_send  = (state == ST_SEND);
    assign send_nxt = (state_nxt == ST_SEND);
    assign bit_nxt  = shift_nxt[bit_idx_nxt];

    ws_bit_timer #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_bit_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .advance  (in_send),
        .send_nxt (send_nxt),
        .bit_nxt  (bit_nxt),
        .bit_end  (bit_end),
        .do_out   (DO)
    );

endmodule

// File: tb/tb_pixel_stream_controller.sv
// Bench for pixel_stream_controller: one instance with default timing and
// one with short timing (T_BIT=10, T0H=3, T1H=6, RESET_CYCLES=5). A
// behavioural model tracks, per instance, the elapsed cycles into the
// current pixel and the latch, and every cycle the outputs are compared
// against it. Directed frames additionally pin pulse widths and counts
// to hand-computed numbers.
module tb_pixel_stream_controller;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rn [2] = '{1'b0, 1'b0};
    logic [23:0] pd [2] = '{24'd0, 24'd0};
    logic        pl [2] = '{1'b0, 1'b0};
    logic        pv [2] = '{1'b0, 1'b0};

    logic rdy0, do0, busy0, fd0, ur0;
    logic rdy1, do1, busy1, fd1, ur1;

    pixel_stream_controller u_dut0 (
        .clk(clk), .reset_n(rn[0]), .pixel_data(pd[0]), .pixel_last(pl[0]),
        .pixel_valid(pv[0]), .pixel_ready(rdy0), .DO(do0), .busy(busy0),
        .frame_done(fd0), .underrun(ur0)
    );

    pixel_stream_controller #(
        .T_BIT(10), .T0H(3), .T1H(6), .RESET_CYCLES(5)
    ) u_dut1 (
        .clk(clk), .reset_n(rn[1]), .pixel_data(pd[1]), .pixel_last(pl[1]),
        .pixel_valid(pv[1]), .pixel_ready(rdy1), .DO(do1), .busy(busy1),
        .frame_done(fd1), .underrun(ur1)
    );

    function automatic int p_tb(input int d); return (d == 0) ? 61    : 10; endfunction
    function automatic int p_t0(input int d); return (d == 0) ? 18    : 3;  endfunction
    function automatic int p_t1(input int d); return (d == 0) ? 33    : 6;  endfunction
    function automatic int p_rc(input int d); return (d == 0) ? 15000 : 5;  endfunction

    function automatic logic [4:0] dut_out(input int d);  // {ready, DO, busy, frame_done, underrun}
        return (d == 0) ? {rdy0, do0, busy0, fd0, ur0} : {rdy1, do1, busy1, fd1, ur1};
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode 0 = idle, 1 = sending (t = cycles since the pixel started),
    // 2 = latching (lat = cycles spent low so far).
    int          m_mode [2] = '{0, 0};
    int          m_t    [2] = '{0, 0};
    int          m_lat  [2] = '{0, 0};
    logic [23:0] m_pix  [2] = '{24'd0, 24'd0};
    logic        m_last [2] = '{1'b0, 1'b0};
    logic        m_live [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rn[d]) begin
                m_mode[d] = 0; m_t[d] = 0; m_lat[d] = 0; m_live[d] = 1'b1;
            end else if (m_mode[d] == 0) begin
                if (pv[d]) begin
                    m_mode[d] = 1; m_t[d] = 0; m_pix[d] = pd[d]; m_last[d] = pl[d];
                end
            end else if (m_mode[d] == 1) begin
                if (m_t[d] == 24 * p_tb(d) - 1) begin
                    if (pv[d]) begin
                        m_t[d] = 0; m_pix[d] = pd[d]; m_last[d] = pl[d];
                    end else begin
                        m_mode[d] = 2; m_lat[d] = 0;
                    end
                end else begin
                    m_t[d] = m_t[d] + 1;
                end
            end else begin
                if (m_lat[d] == p_rc(d) - 1) m_mode[d] = 0;
                else m_lat[d] = m_lat[d] + 1;
            end
        end
    end

    // ---------------- per-cycle compare + waveform statistics ----------------
    int st_busy [2] = '{0, 0};
    int st_fd   [2] = '{0, 0};
    int st_ur   [2] = '{0, 0};
    int st_rb   [2] = '{0, 0};
    int run     [2] = '{0, 0};
    int hw0 [$];
    int hw1 [$];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_live[d]) begin
                logic [4:0] o;
                logic e_rdy, e_do, e_busy, e_fd, e_ur, at_end;
                int bit_i;
                o      = dut_out(d);
                at_end = (m_mode[d] == 1) && (m_t[d] == 24 * p_tb(d) - 1);
                e_busy = (m_mode[d] != 0);
                e_do   = 1'b0;
                if (m_mode[d] == 1) begin
                    bit_i = 23 - m_t[d] / p_tb(d);
                    e_do  = ((m_t[d] % p_tb(d)) < (m_pix[d][bit_i] ? p_t1(d) : p_t0(d)));
                end
                e_rdy = rn[d] && ((m_mode[d] == 0) || at_end);
                e_ur  = rn[d] && at_end && !pv[d] && !m_last[d];
                e_fd  = rn[d] && (m_mode[d] == 2) && (m_lat[d] == p_rc(d) - 1);
                check($sformatf("dut%0d pixel_ready", d), o[4], e_rdy);
                check($sformatf("dut%0d DO", d),          o[3], e_do);
                check($sformatf("dut%0d busy", d),        o[2], e_busy);
                check($sformatf("dut%0d frame_done", d),  o[1], e_fd);
                check($sformatf("dut%0d underrun", d),    o[0], e_ur);

                if (o[2]) st_busy[d]++;
                if (o[1]) st_fd[d]++;
                if (o[0]) st_ur[d]++;
                if (o[4] && o[2]) st_rb[d]++;
                if (o[3]) begin
                    run[d]++;
                end else if (run[d] > 0) begin
                    if (d == 0) hw0.push_back(run[d]);
                    else        hw1.push_back(run[d]);
                    run[d] = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_stats(input int d);
        st_busy[d] = 0; st_fd[d] = 0; st_ur[d] = 0; st_rb[d] = 0; run[d] = 0;
        if (d == 0) hw0.delete(); else hw1.delete();
    endtask

    function automatic int hw_at(input int d, input int i);
        if (d == 0) return (i < hw0.size()) ? hw0[i] : -1;
        return (i < hw1.size()) ? hw1[i] : -1;
    endfunction

    // Presents a pixel and returns once it is accepted; waited = cycles
    // spent presenting it (1 = accepted on the first cycle).
    task automatic send_pixel(input int d, input logic [23:0] data, input logic last,
                              output int waited);
        logic hs;
        hs = 1'b0; waited = 0;
        pd[d] = data; pl[d] = last; pv[d] = 1'b1;
        while (!hs && waited < 40000) begin
            @(negedge clk);
            hs = (d == 0) ? rdy0 : rdy1;
            tick();
            waited++;
        end
        if (!hs) check($sformatf("dut%0d accept timeout", d), 0, 1);
    endtask

    task automatic wait_fd(input int d, input int limit);
        logic seen;
        int n;
        seen = 1'b0; n = 0;
        while (!seen && n < limit) begin
            @(negedge clk);
            seen = (d == 0) ? fd0 : fd1;
            tick();
            n++;
        end
        if (!seen) check($sformatf("dut%0d frame_done timeout", d), 0, 1);
    endtask

    // ---------------- default-timing instance ----------------
    task automatic run_dut0();
        int w;
        logic [23:0] pat;
        logic [23:0] px [3];

        tick(); tick();
        @(negedge clk);
        check("reset ready", rdy0, 0);
        check("reset busy", busy0, 0);
        check("reset DO", do0, 0);
        tick();
        rn[0] = 1'b1;
        @(negedge clk);
        check("ready after reset", rdy0, 1);
        tick();

        // Single last pixel: 24 bits of 61 cycles, widths 33/18, 15000 latch.
        clear_stats(0);
        pat = 24'hA50F81;
        send_pixel(0, pat, 1'b1, w);
        pv[0] = 1'b0;
        wait_fd(0, 20000);
        check("single: high pulses", hw0.size(), 24);
        for (int i = 0; i < 24; i++)
            check($sformatf("single: width bit %0d", 23 - i), hw_at(0, i), pat[23 - i] ? 33 : 18);
        check("single: busy cycles", st_busy[0], 16464);
        check("single: frame_done count", st_fd[0], 1);
        check("single: underrun count", st_ur[0], 0);

        // Three back-to-back pixels, then valid held high through the latch.
        clear_stats(0);
        for (int k = 0; k < 3; k++) px[k] = 24'($urandom());
        for (int k = 0; k < 3; k++) send_pixel(0, px[k], (k == 2), w);
        pv[0] = 1'b0;
        repeat (24 * 61 + 100) tick();
        pd[0] = 24'hFFFFFF; pl[0] = 1'b0; pv[0] = 1'b1;
        wait_fd(0, 20000);
        check("stream: high pulses", hw0.size(), 72);
        for (int k = 0; k < 3; k++) begin
            pat = px[k];
            for (int i = 0; i < 24; i++)
                check($sformatf("stream: px%0d width bit %0d", k, 23 - i),
                      hw_at(0, 24 * k + i), pat[23 - i] ? 33 : 18);
        end
        check("stream: ready while busy", st_rb[0], 3);
        check("stream: busy cycles", st_busy[0], 19392);
        check("stream: frame_done count", st_fd[0], 1);
        check("stream: underrun count", st_ur[0], 0);

        // The waiting pixel goes in on the first idle cycle; no last -> underrun.
        clear_stats(0);
        send_pixel(0, 24'hFFFFFF, 1'b0, w);
        pv[0] = 1'b0;
        check("accept on first idle cycle", w, 1);
        wait_fd(0, 20000);
        check("underrun: high pulses", hw0.size(), 24);
        for (int i = 0; i < 24; i++)
            check($sformatf("underrun: width %0d", i), hw_at(0, i), 33);
        check("underrun: underrun count", st_ur[0], 1);
        check("underrun: frame_done count", st_fd[0], 1);
        check("underrun: busy cycles", st_busy[0], 16464);

        // One-cycle reset during bit 12 aborts the frame silently.
        clear_stats(0);
        send_pixel(0, 24'($urandom()), 1'b1, w);
        pv[0] = 1'b0;
        repeat (11 * 61 + 20) tick();
        rn[0] = 1'b0;
        tick();
        rn[0] = 1'b1;
        @(negedge clk);
        check("abort: DO", do0, 0);
        check("abort: busy", busy0, 0);
        check("abort: ready", rdy0, 1);
        repeat (200) tick();
        check("abort: frame_done count", st_fd[0], 0);
        check("abort: underrun count", st_ur[0], 0);
    endtask

    // ---------------- short-timing instance ----------------
    task automatic run_dut1();
        int w;
        repeat (3) tick();
        rn[1] = 1'b1;
        tick();

        clear_stats(1);
        send_pixel(1, 24'h800000, 1'b1, w);
        pv[1] = 1'b0;
        wait_fd(1, 1000);
        check("short: high pulses", hw1.size(), 24);
        check("short: first width", hw_at(1, 0), 6);
        for (int i = 1; i < 24; i++)
            check($sformatf("short: width %0d", i), hw_at(1, i), 3);
        check("short: busy cycles", st_busy[1], 245);
        check("short: frame_done count", st_fd[1], 1);

        // Random pixels, gaps, back-to-back runs and resets; the per-cycle
        // compare against the model does the checking.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 250)) tick();
                rn[1] = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                rn[1] = 1'b1;
            end else begin
                send_pixel(1, 24'($urandom()), ($urandom_range(0, 2) == 0), w);
                if ($urandom_range(0, 1) == 0) begin
                    pv[1] = 1'b0;
                    repeat ($urandom_range(0, 300)) tick();
                end
            end
        end
        pv[1] = 1'b0;
        repeat (400) tick();
    endtask

    initial begin
        fork
            run_dut0();
            run_dut1();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_stream_controller.md
PIXEL_STREAM_CONTROLLER -- requirements
Module: pixel_stream_controller

Interface
REQ-001 Parameter T_BIT, default 61, SHALL set the bit period in clk cycles (1220 ns at 50 MHz).
REQ-002 Parameter T0H, default 18, SHALL set the high time of a 0 bit in cycles (360 ns).
REQ-003 Parameter T1H, default 33, SHALL set the high time of a 1 bit in cycles (660 ns).
REQ-004 Parameter RESET_CYCLES, default 15000, SHALL set the latch low time in cycles (300 us).
REQ-005 clk  input  1  SHALL be the 50 MHz clock; one clock domain, all logic on posedge clk.
REQ-006 reset_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-007 pixel_data  input  24  SHALL carry the colour word, transmitted MSB (bit 23) first; channel order is the producer's concern.
REQ-008 pixel_last  input  1  SHALL mark the final pixel of a frame; qualified by pixel_valid.
REQ-009 pixel_valid  input  1  SHALL indicate pixel_data and pixel_last are valid.
REQ-010 pixel_ready  output  1  SHALL indicate the block accepts a pixel this cycle.
REQ-011 DO  output  1  SHALL be the registered serial LED data line.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-013 frame_done  output  1  SHALL pulse for one cycle when a latch period completes.
REQ-014 underrun  output  1  SHALL pulse for one cycle when a pixel ends with no successor and no pixel_last.

Function
REQ-015 States SHALL be IDLE, SEND and LATCH; handshake = pixel_valid & pixel_ready at posedge.
REQ-016 pixel_ready SHALL be 1 in IDLE, and in SEND only on the final cycle of bit 0 (bit_idx=0, cyc_cnt=T_BIT-1); 0 otherwise, including all of LATCH.
REQ-017 Handshake in IDLE SHALL load the shift register and pixel_last, set bit_idx=23, cyc_cnt=0, enter SEND; DO is high on the next cycle (1-cycle latency).
REQ-018 In SEND, cyc_cnt SHALL count 0..T_BIT-1 then wrap to 0 and decrement bit_idx.
REQ-019 In SEND, DO SHALL be 1 while cyc_cnt < (current bit ? T1H : T0H), else 0.
REQ-020 Handshake on the final cycle of bit 0 SHALL start bit 23 of the new pixel the next cycle, no gap.
REQ-021 At end of bit 0 with no handshake: stored pixel_last=1 -> LATCH; stored pixel_last=0 -> LATCH with one-cycle underrun pulse.
REQ-022 LATCH SHALL hold DO=0 for exactly RESET_CYCLES cycles, then enter IDLE with frame_done pulsed in the same cycle as the transition.
REQ-023 In IDLE, DO SHALL be 0; pixel_valid while pixel_ready=0 SHALL be ignored.
REQ-024 cyc_cnt SHALL be $clog2(T_BIT) bits, latch counter $clog2(RESET_CYCLES+1) bits, bit_idx 5 bits; no counter SHALL exceed its terminal value.
REQ-025 Parameters SHALL satisfy 0 < T0H < T1H < T_BIT and RESET_CYCLES >= 1; elaboration SHALL fail otherwise.

Reset
REQ-026 reset_n low at posedge SHALL force IDLE, DO=0, pixel_ready=0 that cycle, busy=0, frame_done=0, underrun=0, counters and shift register cleared.
REQ-027 Reset mid-SEND or mid-LATCH SHALL abort the frame without pulsing frame_done or underrun; reset dominates any simultaneous handshake.
REQ-028 pixel_ready SHALL go 1 on the first cycle after reset_n returns high.

Structure
REQ-029 Package ws_pkg SHALL hold the state enum and default timing constants (T_BIT, T0H, T1H, RESET_CYCLES).
REQ-030 The bit-period counter and DO high/low compare SHALL be one sub-module, ws_bit_timer; sequencing, shift register and latch counter stay in the top.

Verification
REQ-031 Single pixel 24'hA5_0F_81, pixel_last=1 -> 24 bits, each 61 cycles; high widths 33/18 matching the MSB-first pattern; 15000 low cycles; one frame_done pulse.
REQ-032 Three pixels, valid held high, last on third -> pixel_ready pulses exactly at the final cycle of each bit 0; 72 contiguous bits (4392 cycles), no gap.
REQ-033 One pixel 24'hFFFFFF with pixel_last=0, then no valid -> 24 x 33-cycle highs, underrun pulse once at LATCH entry, then frame_done after 15000 cycles.
REQ-034 reset_n low for 1 cycle during bit 12 of a pixel -> DO=0 and IDLE next cycle, no frame_done/underrun, pixel_ready=1 after release.
REQ-035 pixel_valid held high throughout LATCH -> no acceptance until IDLE; next pixel accepted on first IDLE cycle after frame_done.
REQ-036 Override T_BIT=10, T0H=3, T1H=6, RESET_CYCLES=5, pixel 24'h800000 -> first bit high 6 cycles, remaining 23 bits high 3 cycles, latch 5 cycles.
